qspi_ram_responder: RTL and testbench

Synthesizable quad-SPI serial SRAM responder: the target end of the QSPI RAM bus that `tt_um_as1802` drives as initiator. It oversamples the chip-select, serial clock and IO lines in the system clock domain and decodes quad-mode read and write commands. It serves data through a simple byte-wide memory port, so the same CPU can run against an FPGA block RAM in place of an external PSRAM/SRAM chip.

---
 rtl/qspi_ram_responder_if.sv | 27 ++
 rtl/qspi_ram_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_qspi_ram_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_ram_responder_if.sv
// Quad-SPI RAM bus bundle: chip select, serial clock and the four IO lines.
// The master drives csn/sclk/io_in; the slave answers on io_out/io_oe.
`timescale 1ns/1ps

interface qspi_ram_responder_if;
  logic       csn;
  logic       sclk;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;

  modport master (
    output csn,
    output sclk,
    output io_in,
    input  io_out,
    input  io_oe
  );

  modport slave (
    input  csn,
    input  sclk,
    input  io_in,
    output io_out,
    output io_oe
  );
endinterface

// File: rtl/qspi_ram_responder.sv
// Quad-SPI serial SRAM responder oversampled in the clk domain, byte-wide memory port.
// Optional read-mode-register command 0x05 when QSPI_RESP_RDMR_EN is defined.
`timescale 1ns/1ps

module qspi_ram_responder #(
  parameter int ADDR_W       = 17,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_ram_responder_if.slave   bus,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_READ,
    S_WRITE,
    S_IGNORE,
    S_RDMR
  } state_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic [1:0] csn_q;
  logic [2:0] sclk_q;
  logic [3:0] io0_q;
  logic [3:0] io1_q;
  logic       csn_prev_q;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-5:0] sh_q;
  logic              is_rd_q;
  logic              half_q;
  logic [7:0]        rd_buf_q;
  logic [3:0]        lo_q;
  logic [3:0]        wr_hi_q;
  logic              lat_q;
  logic [3:0]        io_out_q;
  logic              io_oe_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q;

  logic              csn_s;
  logic              csn_fall;
  logic              rise;
  logic              fall;
  logic [3:0]        nib_s;
  logic [ADDR_W-5:0] sh_d;
  logic [7:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_inc_d;

  // Pure synchronizers: left unreset so a reset while csn is
  // held low cannot be mistaken for a fresh csn fall.
  always_ff @(posedge clk) begin
    csn_q      <= {csn_q[0], bus.csn};
    sclk_q     <= {sclk_q[1:0], bus.sclk};
    io0_q      <= bus.io_in;
    io1_q      <= io0_q;
    csn_prev_q <= csn_q[1];
  end

  assign csn_s      = csn_q[1];
  assign csn_fall   = csn_prev_q & ~csn_s;
  assign rise       = sclk_q[1] & ~sclk_q[2];
  assign fall       = ~sclk_q[1] & sclk_q[2];
  assign nib_s      = io1_q;
  assign sh_d       = {sh_q[ADDR_W-9:0], nib_s};
  assign cmd_d      = {sh_q[3:0], nib_s};
  assign addr_d     = {sh_q, nib_s};
  assign addr_inc_d = mem_addr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      is_rd_q     <= 1'b0;
      half_q      <= 1'b0;
      rd_buf_q    <= '0;
      lo_q        <= '0;
      wr_hi_q     <= '0;
      lat_q       <= 1'b0;
      io_out_q    <= '0;
      io_oe_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= ~csn_s;
      lat_q    <= mem_re_q;
      if (lat_q)
        rd_buf_q <= mem_rdata;
      if (mem_we_q)
        mem_addr_q <= addr_inc_d;
      if (csn_s) begin
        state_q <= S_IDLE;
        io_oe_q <= 1'b0;
        half_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (csn_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
            end
          end
          S_CMD: begin
            if (rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q[0]) begin
                cnt_q  <= '0;
                half_q <= 1'b0;
                case (cmd_d)
                  8'h02: begin
                    state_q <= S_ADDR;
                    is_rd_q <= 1'b0;
                  end
                  8'h03, 8'h0B: begin
                    state_q <= S_ADDR;
                    is_rd_q <= 1'b1;
                  end
`ifdef QSPI_RESP_RDMR_EN
                  8'h05: state_q <= S_RDMR;
`else
`endif
                  default: state_q <= S_IGNORE;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == 8'd5) begin
                cnt_q      <= '0;
                half_q     <= 1'b0;
                mem_addr_q <= addr_d;
                if (is_rd_q) begin
                  mem_re_q <= 1'b1;
                  state_q  <= (DUMMY_CYCLES == 0) ? S_READ : S_DUMMY;
                end else begin
                  state_q <= S_WRITE;
                end
              end
            end
          end
          S_DUMMY: begin
            if (rise) begin
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == DUMMY_LAST) begin
                cnt_q   <= '0;
                state_q <= S_READ;
              end
            end
          end
          S_READ: begin
            // Low nibble is held apart so the prefetch may refill rd_buf_q early.
            if (fall) begin
              io_oe_q <= 1'b1;
              half_q  <= ~half_q;
              if (!half_q) begin
                io_out_q <= rd_buf_q[7:4];
                lo_q     <= rd_buf_q[3:0];
              end else begin
                io_out_q <= lo_q;
              end
            end
            if (rise && half_q) begin
              mem_addr_q <= addr_inc_d;
              mem_re_q   <= 1'b1;
            end
          end
          S_WRITE: begin
            if (rise) begin
              half_q <= ~half_q;
              if (!half_q) begin
                wr_hi_q <= nib_s;
              end else begin
                mem_wdata_q <= {wr_hi_q, nib_s};
                mem_we_q    <= 1'b1;
              end
            end
          end
          S_RDMR: begin
            if (fall) begin
              io_oe_q  <= 1'b1;
              half_q   <= ~half_q;
              io_out_q <= half_q ? 4'h0 : 4'h4;
            end
          end
          S_IGNORE: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.io_out = io_out_q;
  assign bus.io_oe  = {4{io_oe_q}};
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed bench for qspi_ram_responder: vector table of bus transactions
// plus hand sequences for abort, reset mid-read and an 8x-ratio burst.
`timescale 1ns/1ps

module tb_qspi_ram_responder;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qspi_ram_responder_if bus ();

  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          busy;

  qspi_ram_responder #(
    .ADDR_W       (AW),
    .DUMMY_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy)
  );

  logic [7:0]    mem [logic [AW-1:0]];
  logic [AW+7:0] wlog [$];
  int            re_cnt = 0;
  int            oe_cnt = 0;

  // Unwritten locations read back as addr[7:0] ^ 0x5A.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr]
                                        : (mem_addr[7:0] ^ 8'h5A);
      re_cnt++;
    end
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (bus.io_oe != 4'h0)
      oe_cnt++;
  end

  int checks = 0;
  int errors = 0;
  int hp = 80;

  logic [3:0] smp [16];
  logic [3:0] soe [16];
  logic       sbusy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic start();
    @(posedge clk);
    #(1 + $urandom_range(0, 8));
    bus.csn = 1'b0;
    #(hp);
  endtask

  task automatic stop();
    #(hp);
    bus.csn = 1'b1;
    #(2 * hp);
  endtask

  task automatic nib(input logic [3:0] d, output logic [3:0] o,
                     output logic [3:0] oe);
    bus.io_in = d;
    #(hp);
    o  = bus.io_out;
    oe = bus.io_oe;
    bus.sclk = 1'b1;
    #(hp);
    bus.sclk = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [3:0] o, oe;
    nib(cmd[7:4], o, oe);
    nib(cmd[3:0], o, oe);
    for (int k = 0; k < 6; k++)
      nib(addr[23-4*k -: 4], o, oe);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr,
                      input logic [15:0] wd, input int ncyc);
    logic [3:0] dv [16];
    for (int i = 0; i < 16; i++) dv[i] = 4'h0;
    dv[0] = cmd[7:4];
    dv[1] = cmd[3:0];
    for (int k = 0; k < 6; k++) dv[2+k] = addr[23-4*k -: 4];
    for (int k = 0; k < 4; k++) dv[8+k] = wd[15-4*k -: 4];
    start();
    for (int i = 0; i < ncyc; i++) begin
      nib(dv[i], smp[i], soe[i]);
      if (i == 1) sbusy = busy;
    end
    stop();
  endtask

  typedef struct {
    string         nm;
    logic [7:0]    cmd;
    logic [23:0]   addr;
    logic [15:0]   wd;
    int            ncyc;
    int            dst;
    logic [15:0]   erd;
    logic          edrv;
    int            ewe;
    logic [AW-1:0] wa0;
    logic [7:0]    wv0;
    logic [AW-1:0] wa1;
    logic [7:0]    wv1;
    int            ere;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int re0, oe0, w0;
    logic [3:0] o, oe;
    logic [7:0] b;

    vecs[0] = '{"wr10", 8'h02, 24'h000010, 16'hA53C, 12, 0, 16'h0, 1'b0,
                2, 17'h00010, 8'hA5, 17'h00011, 8'h3C, 0};
    vecs[1] = '{"rd10", 8'h03, 24'h000010, 16'h0, 14, 10, 16'hA53C, 1'b1,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 3};
    vecs[2] = '{"wrwrap", 8'h02, 24'h01FFFF, 16'h1122, 12, 0, 16'h0, 1'b0,
                2, 17'h1FFFF, 8'h11, 17'h00000, 8'h22, 0};
    vecs[3] = '{"rdwrap", 8'h0B, 24'h01FFFF, 16'h0, 14, 10, 16'h1122, 1'b1,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 3};
    vecs[4] = '{"rdhiaddr", 8'h03, 24'hFE0010, 16'h0, 14, 10, 16'hA53C, 1'b1,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 3};
    vecs[5] = '{"unk9f", 8'h9F, 24'h000000, 16'hFFFF, 12, 0, 16'h0, 1'b0,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 0};
`ifdef QSPI_RESP_RDMR_EN
    vecs[6] = '{"rdmr", 8'h05, 24'h000000, 16'h0, 12, 2, 16'h4040, 1'b1,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 0};
`else
    vecs[6] = '{"rdmr_off", 8'h05, 24'h000000, 16'h0, 12, 2, 16'h0, 1'b0,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 0};
`endif
    vecs[7] = '{"rdpat", 8'h03, 24'h000123, 16'h0, 14, 10, 16'h797E, 1'b1,
                0, 17'h0, 8'h0, 17'h0, 8'h0, 3};

    bus.csn   = 1'b1;
    bus.sclk  = 1'b0;
    bus.io_in = 4'h0;
    rst       = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_io_out", 32'(bus.io_out), 32'h0);
    chk("rst_io_oe", 32'(bus.io_oe), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #(2 * hp);

    for (int v = 0; v < 8; v++) begin
      re0 = re_cnt;
      oe0 = oe_cnt;
      w0  = wlog.size();
      xfer(vecs[v].cmd, vecs[v].addr, vecs[v].wd, vecs[v].ncyc);
      chk({vecs[v].nm, "_busy_in"}, 32'(sbusy), 32'h1);
      chk({vecs[v].nm, "_busy_out"}, 32'(busy), 32'h0);
      chk({vecs[v].nm, "_we_cnt"}, 32'(wlog.size() - w0), 32'(vecs[v].ewe));
      chk({vecs[v].nm, "_re_cnt"}, 32'(re_cnt - re0), 32'(vecs[v].ere));
      if (vecs[v].ewe > 0)
        chk({vecs[v].nm, "_we0"},
            32'(wlog.size() > w0 ? wlog[w0] : '1),
            32'({vecs[v].wa0, vecs[v].wv0}));
      if (vecs[v].ewe > 1)
        chk({vecs[v].nm, "_we1"},
            32'(wlog.size() > w0 + 1 ? wlog[w0+1] : '1),
            32'({vecs[v].wa1, vecs[v].wv1}));
      if (vecs[v].edrv) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("%s_nib%0d", vecs[v].nm, k),
              32'(smp[vecs[v].dst+k]), 32'(vecs[v].erd[15-4*k -: 4]));
          chk($sformatf("%s_oe%0d", vecs[v].nm, k),
              32'(soe[vecs[v].dst+k]), 32'hF);
        end
      end else begin
        chk({vecs[v].nm, "_oe_quiet"}, 32'(oe_cnt - oe0), 32'h0);
      end
    end

    // Write aborted after one data nibble.
    w0 = wlog.size();
    start();
    hdr(8'h02, 24'h000040);
    nib(4'h7, o, oe);
    #(hp);
    bus.csn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    #(4 * hp);
    chk("abort_no_we", 32'(wlog.size() - w0), 32'h0);

    // Reset in the middle of a read while driving.
    start();
    hdr(8'h03, 24'h000010);
    nib(4'h0, o, oe);
    nib(4'h0, o, oe);
    nib(4'h0, o, oe);
    chk("mid_nib", 32'(o), 32'hA);
    chk("mid_oe", 32'(oe), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_io_out", 32'(bus.io_out), 32'h0);
    chk("mid_rst_io_oe", 32'(bus.io_oe), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_mem_re", 32'(mem_re), 32'h0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'h0);
    chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    bus.csn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #(2 * hp);
    xfer(8'h03, 24'h000011, 16'h0, 14);
    chk("post_rst_rd", 32'({smp[10], smp[11], smp[12], smp[13]}), 32'h3C48);

    // 64-byte burst at clk = 8x SCLK.
    hp = 40;
    start();
    hdr(8'h03, 24'h000100);
    nib(4'h0, o, oe);
    nib(4'h0, o, oe);
    for (int i = 0; i < 64; i++) begin
      nib(4'h0, o, oe);
      b[7:4] = o;
      nib(4'h0, o, oe);
      b[3:0] = o;
      chk($sformatf("burst_byte%0d", i), 32'(b), 32'(8'(i) ^ 8'h5A));
    end
    stop();
    hp = 80;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
